mips_multicycle_ctrl: RTL and testbench

Control unit for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects, write enables and the 3-bit ALUControl code consumed by the ALU. It is the producer side of the ALU's control interface and also handshakes with the unified instruction/data memory.

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/mips_multicycle_ctrl_if.sv | 37 +++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 31 +++
 rtl/mips_multicycle_ctrl.sv | 148 ++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes,
// ALU control codes, ALUOp, datapath mux selects and the FSM state type.
package mips_ctrl_pkg;

    // Opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes, instruction[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUControl codes understood by the ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALUOp: what the FSM asks of the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMX4 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    // Controller states
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath
// plus memory (slave). Instruction fields, flags and memory handshake flow in;
// mux selects, enables and the ALU code flow out.
interface mips_multicycle_ctrl_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       illegal_op;

    modport master (
        input  op, funct, zero, mem_ready,
        output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op
    );

endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Translates the FSM's ALUOp plus the instruction funct field into the 3-bit
// ALUControl code. Unknown funct values fall back to add silently.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // ALUOp selects a fixed operation or defers to the funct field
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Walks each instruction through fetch, decode,
// execute, memory and writeback, decoding all datapath controls from the
// current state. illegal_op is registered so it pulses in the cycle after the
// offending DECODE.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input logic                          clk,
    input logic                          reset_n,
    mips_multicycle_ctrl_if.master       bus
);

    state_t     state_q, state_d;
    logic       illegal_op_q, illegal_op_d;
    alu_op_t    alu_op;
    logic [2:0] alu_control;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       mem_write;
    logic       reg_write;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (bus.funct),
        .alu_control (alu_control)
    );

    // State and illegal-opcode flag; reset drops straight back to FETCH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    // Next-state and per-state datapath control decode
    always_comb begin
        state_d      = state_q;
        illegal_op_d = 1'b0;
        alu_op       = ALUOP_ADD;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = SRCB_REG;
        bus.PCSrc    = PCSRC_ALURESULT;

        case (state_q)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = SRCB_FOUR;
                bus.PCSrc   = PCSRC_ALURESULT;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                bus.ALUSrcB = SRCB_IMMX4;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d      = FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                state_d     = (bus.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWR: begin
                mem_write = 1'b1;
                bus.IorD  = 1'b1;
                if (bus.mem_ready) state_d = FETCH;
            end
            MEMWB: begin
                reg_write    = 1'b1;
                bus.MemtoReg = 1'b1;
                state_d      = FETCH;
            end
            EXECUTE: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_REG;
                alu_op      = ALUOP_FUNCT;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                bus.RegDst = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                state_d     = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcA = 1'b1;
                alu_op      = ALUOP_SUB;
                bus.PCSrc   = PCSRC_ALUOUT;
                branch      = 1'b1;
                state_d     = FETCH;
            end
            JUMP: begin
                bus.PCSrc = PCSRC_JUMP;
                pc_write  = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write enables are held low while reset is asserted, even though the
    // state already reads FETCH and mem_ready may be high
    assign bus.IRWrite    = reset_n & ir_write;
    assign bus.MemWrite   = reset_n & mem_write;
    assign bus.RegWrite   = reset_n & reg_write;
    assign bus.PCEn       = reset_n & (pc_write | (branch & bus.zero));
    assign bus.ALUControl = alu_control;
    assign bus.illegal_op = illegal_op_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS controller. Each task runs one
// instruction scenario cycle by cycle against hand-written state and control
// tables. Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    mips_multicycle_ctrl_if bus_if ();

    mips_multicycle_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of every controller output:
    // [16] IorD [15] MemRead [14] MemWrite [13] IRWrite [12] RegDst
    // [11] MemtoReg [10] RegWrite [9] ALUSrcA [8:7] ALUSrcB [6:4] ALUControl
    // [3:2] PCSrc [1] PCEn [0] illegal_op
    logic [16:0] ctl;
    assign ctl = {bus_if.IorD, bus_if.MemRead, bus_if.MemWrite, bus_if.IRWrite,
                  bus_if.RegDst, bus_if.MemtoReg, bus_if.RegWrite, bus_if.ALUSrcA,
                  bus_if.ALUSrcB, bus_if.ALUControl, bus_if.PCSrc, bus_if.PCEn,
                  bus_if.illegal_op};

    localparam logic [16:0] B_IORD     = 17'h1 << 16;
    localparam logic [16:0] B_MEMREAD  = 17'h1 << 15;
    localparam logic [16:0] B_MEMWRITE = 17'h1 << 14;
    localparam logic [16:0] B_IRWRITE  = 17'h1 << 13;
    localparam logic [16:0] B_REGDST   = 17'h1 << 12;
    localparam logic [16:0] B_MEMTOREG = 17'h1 << 11;
    localparam logic [16:0] B_REGWRITE = 17'h1 << 10;
    localparam logic [16:0] B_SRCA     = 17'h1 << 9;
    localparam logic [16:0] B_SRCB01   = 17'h1 << 7;
    localparam logic [16:0] B_SRCB10   = 17'h1 << 8;
    localparam logic [16:0] B_SRCB11   = 17'h3 << 7;
    localparam logic [16:0] B_ALU_SUB  = 17'h1 << 4;
    localparam logic [16:0] B_ALU_SLT  = 17'h5 << 4;
    localparam logic [16:0] B_PCSRC01  = 17'h1 << 2;
    localparam logic [16:0] B_PCSRC10  = 17'h2 << 2;
    localparam logic [16:0] B_PCEN     = 17'h1 << 1;
    localparam logic [16:0] B_ILLEGAL  = 17'h1;

    localparam logic [16:0] E_FETCH_RDY  = B_MEMREAD | B_IRWRITE | B_SRCB01 | B_PCEN;
    localparam logic [16:0] E_FETCH_WAIT = B_MEMREAD | B_SRCB01;
    localparam logic [16:0] E_DECODE     = B_SRCB11;
    localparam logic [16:0] E_ADDRCALC   = B_SRCA | B_SRCB10;
    localparam logic [16:0] E_MEMRD      = B_IORD | B_MEMREAD;
    localparam logic [16:0] E_MEMWR      = B_IORD | B_MEMWRITE;
    localparam logic [16:0] E_MEMWB      = B_REGWRITE | B_MEMTOREG;
    localparam logic [16:0] E_EXEC_SLT   = B_SRCA | B_ALU_SLT;
    localparam logic [16:0] E_EXEC_ADD   = B_SRCA;
    localparam logic [16:0] E_ALUWB      = B_REGWRITE | B_REGDST;
    localparam logic [16:0] E_ADDIWB     = B_REGWRITE;
    localparam logic [16:0] E_BR_TAKEN   = B_SRCA | B_ALU_SUB | B_PCSRC01 | B_PCEN;
    localparam logic [16:0] E_BR_NOT     = B_SRCA | B_ALU_SUB | B_PCSRC01;
    localparam logic [16:0] E_JUMP       = B_PCSRC10 | B_PCEN;

    // Reset at time zero, with mem_ready high to catch an ungated IRWrite/PCEn
    task automatic test_reset();
        reset_n          = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.zero      = 1'b0;
        bus_if.op        = OP_LW;
        bus_if.funct     = 6'b0;
        #2;
        checks++;
        if (dut.state_q !== FETCH) begin
            errors++;
            $display("[TB] FAIL reset_state got %0d want %0d", dut.state_q, FETCH);
        end
        checks++;
        if (ctl !== E_FETCH_WAIT) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want %h", ctl, E_FETCH_WAIT);
        end
        bus_if.mem_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Idle FETCH cycle closing each scenario: confirms the return to FETCH
    task automatic check_back_in_fetch(input string name);
        bus_if.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.state_q !== FETCH) begin
            errors++;
            $display("[TB] FAIL %s_end_state got %0d want %0d", name, dut.state_q, FETCH);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw();
        state_t      st_tab [5] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
        logic [16:0] ex_tab [5] = '{E_FETCH_RDY, E_DECODE, E_ADDRCALC, E_MEMRD, E_MEMWB};
        bus_if.op = OP_LW;
        for (int i = 0; i < 5; i++) begin
            bus_if.mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (dut.state_q !== st_tab[i]) begin
                errors++;
                $display("[TB] FAIL lw_state[%0d] got %0d want %0d", i, dut.state_q, st_tab[i]);
            end
            checks++;
            if (ctl !== ex_tab[i]) begin
                errors++;
                $display("[TB] FAIL lw_ctl[%0d] got %h want %h", i, ctl, ex_tab[i]);
            end
            @(posedge clk);
            #1;
        end
        check_back_in_fetch("lw");
    endtask

    task automatic test_rtype(input logic [5:0] fn, input logic [16:0] exec_exp, input string name);
        state_t      st_tab [4] = '{FETCH, DECODE, EXECUTE, ALUWB};
        logic [16:0] ex_tab [4];
        ex_tab = '{E_FETCH_RDY, E_DECODE, exec_exp, E_ALUWB};
        bus_if.op    = OP_RTYPE;
        bus_if.funct = fn;
        for (int i = 0; i < 4; i++) begin
            bus_if.mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (dut.state_q !== st_tab[i]) begin
                errors++;
                $display("[TB] FAIL %s_state[%0d] got %0d want %0d", name, i, dut.state_q, st_tab[i]);
            end
            checks++;
            if (ctl !== ex_tab[i]) begin
                errors++;
                $display("[TB] FAIL %s_ctl[%0d] got %h want %h", name, i, ctl, ex_tab[i]);
            end
            @(posedge clk);
            #1;
        end
        check_back_in_fetch(name);
    endtask

    // zero is driven high in DECODE both times; only BRANCH may use it
    task automatic test_beq(input logic zero_in_branch, input string name);
        state_t      st_tab [3] = '{FETCH, DECODE, BRANCH};
        logic [16:0] ex_tab [3];
        logic        z_tab  [3];
        ex_tab = '{E_FETCH_RDY, E_DECODE, zero_in_branch ? E_BR_TAKEN : E_BR_NOT};
        z_tab  = '{1'b0, 1'b1, zero_in_branch};
        bus_if.op = OP_BEQ;
        for (int i = 0; i < 3; i++) begin
            bus_if.mem_ready = 1'b1;
            bus_if.zero      = z_tab[i];
            @(negedge clk);
            checks++;
            if (dut.state_q !== st_tab[i]) begin
                errors++;
                $display("[TB] FAIL %s_state[%0d] got %0d want %0d", name, i, dut.state_q, st_tab[i]);
            end
            checks++;
            if (ctl !== ex_tab[i]) begin
                errors++;
                $display("[TB] FAIL %s_ctl[%0d] got %h want %h", name, i, ctl, ex_tab[i]);
            end
            @(posedge clk);
            #1;
        end
        bus_if.zero = 1'b0;
        check_back_in_fetch(name);
    endtask

    task automatic test_sw_wait();
        state_t      st_tab [6] = '{FETCH, DECODE, MEMADR, MEMWR, MEMWR, MEMWR};
        logic [16:0] ex_tab [6] = '{E_FETCH_RDY, E_DECODE, E_ADDRCALC, E_MEMWR, E_MEMWR, E_MEMWR};
        logic        mr_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        bus_if.op = OP_SW;
        for (int i = 0; i < 6; i++) begin
            bus_if.mem_ready = mr_tab[i];
            @(negedge clk);
            checks++;
            if (dut.state_q !== st_tab[i]) begin
                errors++;
                $display("[TB] FAIL sw_state[%0d] got %0d want %0d", i, dut.state_q, st_tab[i]);
            end
            checks++;
            if (ctl !== ex_tab[i]) begin
                errors++;
                $display("[TB] FAIL sw_ctl[%0d] got %h want %h", i, ctl, ex_tab[i]);
            end
            @(posedge clk);
            #1;
        end
        check_back_in_fetch("sw");
    endtask

    // One FETCH wait state, then mem_ready low where it must be ignored
    task automatic test_addi_fetch_wait();
        state_t      st_tab [5] = '{FETCH, FETCH, DECODE, ADDIEX, ADDIWB};
        logic [16:0] ex_tab [5] = '{E_FETCH_WAIT, E_FETCH_RDY, E_DECODE, E_ADDRCALC, E_ADDIWB};
        logic        mr_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bus_if.op = OP_ADDI;
        for (int i = 0; i < 5; i++) begin
            bus_if.mem_ready = mr_tab[i];
            @(negedge clk);
            checks++;
            if (dut.state_q !== st_tab[i]) begin
                errors++;
                $display("[TB] FAIL addi_state[%0d] got %0d want %0d", i, dut.state_q, st_tab[i]);
            end
            checks++;
            if (ctl !== ex_tab[i]) begin
                errors++;
                $display("[TB] FAIL addi_ctl[%0d] got %h want %h", i, ctl, ex_tab[i]);
            end
            @(posedge clk);
            #1;
        end
        check_back_in_fetch("addi");
    endtask

    task automatic test_jump();
        state_t      st_tab [3] = '{FETCH, DECODE, JUMP};
        logic [16:0] ex_tab [3] = '{E_FETCH_RDY, E_DECODE, E_JUMP};
        logic        mr_tab [3] = '{1'b1, 1'b0, 1'b0};
        bus_if.op = OP_J;
        for (int i = 0; i < 3; i++) begin
            bus_if.mem_ready = mr_tab[i];
            @(negedge clk);
            checks++;
            if (dut.state_q !== st_tab[i]) begin
                errors++;
                $display("[TB] FAIL j_state[%0d] got %0d want %0d", i, dut.state_q, st_tab[i]);
            end
            checks++;
            if (ctl !== ex_tab[i]) begin
                errors++;
                $display("[TB] FAIL j_ctl[%0d] got %h want %h", i, ctl, ex_tab[i]);
            end
            @(posedge clk);
            #1;
        end
        check_back_in_fetch("j");
    endtask

    // Bad opcode: back to FETCH, illegal_op high only in the cycle after DECODE
    task automatic test_illegal();
        state_t      st_tab [4] = '{FETCH, DECODE, FETCH, FETCH};
        logic [16:0] ex_tab [4] = '{E_FETCH_RDY, E_DECODE, E_FETCH_WAIT | B_ILLEGAL, E_FETCH_WAIT};
        logic        mr_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bus_if.op = 6'b111111;
        for (int i = 0; i < 4; i++) begin
            bus_if.mem_ready = mr_tab[i];
            @(negedge clk);
            checks++;
            if (dut.state_q !== st_tab[i]) begin
                errors++;
                $display("[TB] FAIL illegal_state[%0d] got %0d want %0d", i, dut.state_q, st_tab[i]);
            end
            checks++;
            if (ctl !== ex_tab[i]) begin
                errors++;
                $display("[TB] FAIL illegal_ctl[%0d] got %h want %h", i, ctl, ex_tab[i]);
            end
            @(posedge clk);
            #1;
        end
        check_back_in_fetch("illegal");
    endtask

    // Reset pulled low between edges while a lw sits in MEMRD
    task automatic test_reset_mid_memrd();
        bus_if.op        = OP_LW;
        bus_if.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus_if.mem_ready = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== MEMRD) begin
            errors++;
            $display("[TB] FAIL midrst_pre_state got %0d want %0d", dut.state_q, MEMRD);
        end
        bus_if.mem_ready = 1'b1;
        reset_n          = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== FETCH) begin
            errors++;
            $display("[TB] FAIL midrst_state got %0d want %0d", dut.state_q, FETCH);
        end
        checks++;
        if (ctl !== E_FETCH_WAIT) begin
            errors++;
            $display("[TB] FAIL midrst_ctl got %h want %h", ctl, E_FETCH_WAIT);
        end
        bus_if.mem_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dut.state_q !== FETCH) begin
            errors++;
            $display("[TB] FAIL midrst_release_state got %0d want %0d", dut.state_q, FETCH);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lw();
        test_rtype(FN_SLT, E_EXEC_SLT, "slt");
        test_beq(1'b1, "beq_taken");
        test_beq(1'b0, "beq_not_taken");
        test_sw_wait();
        test_addi_fetch_wait();
        test_jump();
        test_rtype(6'b111111, E_EXEC_ADD, "rtype_badfunct");
        test_illegal();
        test_reset_mid_memrd();
        test_lw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
